// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified instruction/data memory between fetch and load/store.
// Optional perf counter: define MEM_ARB_PERF_EN to build conflict_cnt.
module mem_port_arbiter #(
  parameter int unsigned MEM_WORDS    = 128,
  parameter int unsigned MAX_D_STREAK = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [7:0]  word_addr,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [1:0]  SaveMethod,
  output logic [31:0] data_in,
  input  logic [31:0] data_out,
  output logic [15:0] conflict_cnt
);

  typedef enum logic {ST_FETCH, ST_DATA} owner_t;

  localparam logic [31:0] ADDR_LIMIT   = 32'(MEM_WORDS * 4);
  localparam logic [2:0]  STREAK_LIMIT = 3'(MAX_D_STREAK);
  localparam logic [31:0] NOP_INSN     = 32'h0000_0013;

  owner_t     owner;
  logic [2:0] streak;
  logic       if_ok;
  logic       d_ok;
  logic       unused_bits;

  assign if_ok = (if_addr < ADDR_LIMIT);
  assign d_ok  = (d_addr < ADDR_LIMIT);

  // Byte-offset bits are ignored; owner is kept as architectural state only.
  assign unused_bits = ^{if_addr[1:0], d_addr[1:0], (owner == ST_DATA)};

  always_comb begin
    d_gnt      = d_req && (!if_req || (streak < STREAK_LIMIT));
    if_gnt     = if_req && !d_gnt;
    word_addr  = '0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    SaveMethod = '0;
    data_in    = '0;
    if (d_gnt) begin
      word_addr = d_addr[9:2];
      MemRead   = d_ok && !d_we;
      MemWrite  = d_ok && d_we;
      if (d_we) begin
        SaveMethod = d_size;
        data_in    = d_wdata;
      end
    end else if (if_gnt) begin
      word_addr = if_addr[9:2];
      MemRead   = if_ok;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= ST_FETCH;
      streak    <= '0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
    end else begin
      if_rvalid <= if_gnt;
      d_rvalid  <= d_gnt;
      d_err     <= d_gnt && !d_ok;
      if (if_gnt)
        if_rdata <= if_ok ? data_out : NOP_INSN;
      if (d_gnt)
        d_rdata <= (d_ok && !d_we) ? data_out : '0;
      if (d_gnt) begin
        owner <= ST_DATA;
        // Streak only grows while fetch is actually being held off.
        if (if_req)
          streak <= (streak == 3'd7) ? streak : streak + 3'd1;
        else
          streak <= '0;
      end else if (if_gnt) begin
        owner  <= ST_FETCH;
        streak <= '0;
      end else begin
        streak <= '0;
      end
    end
  end

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      conflict_cnt <= '0;
    else if (if_req && d_req && (conflict_cnt != '1))
      conflict_cnt <= conflict_cnt + 16'd1;
  end
`else
  assign conflict_cnt = '0;
`endif

endmodule
